// File: rtl/node_io_queue.sv
// Interposer bus node: delivers messages addressed here, forwards or injects others
// through a circular output queue that drives the downstream segment when granted.
module node_io_queue #(
  parameter int NODE_NUMBER      = 0,
  parameter int NODE_COUNT_DIGIT = 3,
  parameter int DIRECTION        = 0,
  parameter int PAYLOAD_WIDTH    = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int CNT_WIDTH        = 8,
  localparam int MSG_SIZE        = PAYLOAD_WIDTH + 2 * NODE_COUNT_DIGIT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [MSG_SIZE-1:0]                  inj_msg,
  input  logic                                 inj_valid,
  output logic                                 inj_ready,
  input  logic [MSG_SIZE-1:0]                  bus_in,
  input  logic                                 rx_en,
  input  logic                                 grant,
  input  logic                                 bypass,
  output logic [MSG_SIZE-1:0]                  bus_out,
  output logic                                 req_valid,
  output logic [NODE_COUNT_DIGIT-1:0]          req_dest,
  output logic                                 rx_valid,
  output logic [MSG_SIZE-NODE_COUNT_DIGIT-1:0] rx_msg,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic [CNT_WIDTH-1:0]                 drop_count,
  output logic [CNT_WIDTH-1:0]                 err_count
);

  localparam int NCD   = NODE_COUNT_DIGIT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int RX_W  = MSG_SIZE - NCD;
  localparam logic [NCD-1:0]   NODE_ID   = NCD'(NODE_NUMBER);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == {CNT_WIDTH{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + CNT_WIDTH'(1);
    end
  endfunction

  function automatic logic dest_legal(input logic [NCD-1:0] dest);
    if (DIRECTION == 0) begin
      return dest > NODE_ID;
    end else begin
      return dest < NODE_ID;
    end
  endfunction

  logic [MSG_SIZE-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [OCC_W-1:0]     occ_r;
  logic                 rx_valid_r;
  logic [RX_W-1:0]      rx_msg_r;
  logic [CNT_WIDTH-1:0] drop_r, err_r;

  logic [NCD-1:0]      bus_dest_s, inj_dest_s;
  logic [MSG_SIZE-1:0] head_s, push_data_s;
  logic                full_s, empty_s, fwd_s, hit_s;
  logic                inj_ready_s, inj_fire_s, inj_legal_s;
  logic                push_s, pop_s, drop_s, err_s;

  // Decode bus/injection addresses and arbitrate the single queue write port
  always_comb begin
    bus_dest_s  = bus_in[MSG_SIZE-1 -: NCD];
    inj_dest_s  = inj_msg[MSG_SIZE-1 -: NCD];
    head_s      = mem_r[rd_ptr_r];
    full_s      = (occ_r == DEPTH_OCC);
    empty_s     = (occ_r == OCC_W'(0));
    fwd_s       = rx_en && (bus_dest_s != NODE_ID);
    hit_s       = rx_en && (bus_dest_s == NODE_ID);
    // reset gating keeps inj_ready low while the node is held in reset
    inj_ready_s = reset && !full_s && !fwd_s;
    inj_fire_s  = inj_valid && inj_ready_s;
    inj_legal_s = dest_legal(inj_dest_s);
    pop_s       = grant && !empty_s;
    drop_s      = fwd_s && full_s;
    err_s       = inj_fire_s && !inj_legal_s;
    push_s      = 1'b0;
    push_data_s = bus_in;
    if (fwd_s && !full_s) begin
      push_s      = 1'b1;
      push_data_s = bus_in;
    end else if (inj_fire_s && inj_legal_s) begin
      push_s      = 1'b1;
      push_data_s = inj_msg;
    end else begin
      push_s      = 1'b0;
      push_data_s = bus_in;
    end
  end

  // Drive downstream bus and status outputs from registered queue state
  always_comb begin
    inj_ready  = inj_ready_s;
    fifo_full  = full_s;
    fifo_empty = empty_s;
    req_valid  = !empty_s;
    rx_valid   = rx_valid_r;
    rx_msg     = rx_msg_r;
    drop_count = drop_r;
    err_count  = err_r;
    if (empty_s) begin
      req_dest = NCD'(0);
    end else begin
      req_dest = head_s[MSG_SIZE-1 -: NCD];
    end
    if (grant && !empty_s) begin
      bus_out = head_s;
    end else if (bypass) begin
      bus_out = bus_in;
    end else begin
      bus_out = {MSG_SIZE{1'b0}};
    end
  end

  // Queue storage; contents are don't-care once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Pointers, occupancy, delivery register and saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      occ_r      <= OCC_W'(0);
      rx_valid_r <= 1'b0;
      rx_msg_r   <= RX_W'(0);
      drop_r     <= CNT_WIDTH'(0);
      err_r      <= CNT_WIDTH'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
      rx_valid_r <= hit_s;
      if (hit_s) begin
        rx_msg_r <= bus_in[RX_W-1:0];
      end
      if (drop_s) begin
        drop_r <= sat_inc(drop_r);
      end
      if (err_s) begin
        err_r <= sat_inc(err_r);
      end
    end
  end

endmodule

// File: tb/tb_node_io_queue.sv
// Directed bench for node_io_queue (node 2, upward direction, 2-bit counters)
// with a queue-based scoreboard of expected bus_out messages.
module tb_node_io_queue;

  localparam int NCD = 3;
  localparam int PW  = 16;
  localparam int MS  = PW + 2 * NCD;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [MS-1:0] inj_msg, bus_in, bus_out;
  logic          inj_valid, inj_ready, rx_en, grant, bypass;
  logic          req_valid, rx_valid, fifo_full, fifo_empty;
  logic [NCD-1:0] req_dest;
  logic [MS-NCD-1:0] rx_msg;
  logic [CW-1:0] drop_count, err_count;

  logic [MS-1:0] exp_q[$];
  logic [MS-1:0] tmp;
  int checks = 0;
  int errors = 0;
  int err_m  = 0;
  int drop_m = 0;

  node_io_queue #(
    .NODE_NUMBER(2), .NODE_COUNT_DIGIT(NCD), .DIRECTION(0),
    .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .inj_msg(inj_msg), .inj_valid(inj_valid),
    .inj_ready(inj_ready), .bus_in(bus_in), .rx_en(rx_en), .grant(grant),
    .bypass(bypass), .bus_out(bus_out), .req_valid(req_valid),
    .req_dest(req_dest), .rx_valid(rx_valid), .rx_msg(rx_msg),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .drop_count(drop_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [MS-1:0] mk(input logic [2:0] d, input logic [2:0] s,
                                       input logic [15:0] p);
    return {d, s, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // legal injections are accepted and queued; illegal ones only bump err_count
  task automatic inject(input logic [MS-1:0] m, input bit legal);
    inj_valid = 1'b1;
    inj_msg   = m;
    #2;
    chk("inj_ready", {63'd0, inj_ready}, 64'd1);
    if (legal) exp_q.push_back(m);
    else if (err_m < 3) err_m++;
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic forward(input logic [MS-1:0] m);
    rx_en  = 1'b1;
    bus_in = m;
    #2;
    chk("inj_ready_fwd", {63'd0, inj_ready}, 64'd0);
    if (exp_q.size() < 8) exp_q.push_back(m);
    else if (drop_m < 3) drop_m++;
    tick();
    rx_en = 1'b0;
  endtask

  task automatic grant_pop(input string tag);
    grant = 1'b1;
    #2;
    chk(tag, {42'd0, bus_out}, {42'd0, exp_q.pop_front()});
    tick();
    grant = 1'b0;
  endtask

  initial begin
    reset = 1'b0; inj_msg = '0; inj_valid = 1'b0; bus_in = '0;
    rx_en = 1'b0; grant = 1'b0; bypass = 1'b0;
    #3;
    chk("rst_empty", {63'd0, fifo_empty}, 64'd1);
    chk("rst_full", {63'd0, fifo_full}, 64'd0);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_req_dest", {61'd0, req_dest}, 64'd0);
    chk("rst_inj_ready", {63'd0, inj_ready}, 64'd0);
    chk("rst_counts", {60'd0, drop_count, err_count}, 64'd0);
    chk("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    bypass = 1'b1; bus_in = mk(3'd4, 3'd1, 16'h55AA);
    #1;
    chk("rst_bypass", {42'd0, bus_out}, {42'd0, 3'd4, 3'd1, 16'h55AA});
    bypass = 1'b0; bus_in = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // inject dest 5, then grant it out
    inject(mk(3'd5, 3'd2, 16'h1234), 1'b1);
    chk("req_valid", {63'd0, req_valid}, 64'd1);
    chk("req_dest", {61'd0, req_dest}, 64'd5);
    grant_pop("bus_out_single");
    chk("empty_after_pop", {63'd0, fifo_empty}, 64'd1);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("grant_on_empty", {63'd0, fifo_empty}, 64'd1);

    // local delivery
    rx_en = 1'b1; bus_in = mk(3'd2, 3'd7, 16'hBEEF);
    #2;
    chk("inj_ready_rx", {63'd0, inj_ready}, 64'd1);
    tick();
    rx_en = 1'b0;
    chk("rx_valid", {63'd0, rx_valid}, 64'd1);
    chk("rx_msg", {45'd0, rx_msg}, {45'd0, 3'd7, 16'hBEEF});
    chk("rx_queue_unchanged", {63'd0, fifo_empty}, 64'd1);
    tick();
    chk("rx_valid_one_cycle", {63'd0, rx_valid}, 64'd0);

    // fill by forwarding, overflow drops, drain in order
    for (int i = 0; i < 8; i++) begin
      forward(mk(3'(7 - (i % 4)), 3'(i), 16'hA000 + 16'(i)));
    end
    chk("full_after_8", {63'd0, fifo_full}, 64'd1);
    forward(mk(3'd6, 3'd0, 16'hDEAD));
    chk("drop_count_1", {62'd0, drop_count}, 64'(drop_m));
    chk("full_after_drop", {63'd0, fifo_full}, 64'd1);
    chk("inj_ready_full", {63'd0, inj_ready}, 64'd0);
    for (int i = 0; i < 8; i++) grant_pop("drain_fwd");
    chk("empty_after_drain", {63'd0, fifo_empty}, 64'd1);

    // illegal injections saturate the error counter
    inject(mk(3'd1, 3'd2, 16'h0001), 1'b0);
    chk("err_count_1", {62'd0, err_count}, 64'(err_m));
    chk("illegal_not_queued", {63'd0, fifo_empty}, 64'd1);
    inject(mk(3'd2, 3'd2, 16'h0002), 1'b0);
    inject(mk(3'd0, 3'd2, 16'h0003), 1'b0);
    inject(mk(3'd1, 3'd2, 16'h0004), 1'b0);
    inject(mk(3'd2, 3'd2, 16'h0005), 1'b0);
    chk("err_count_sat", {62'd0, err_count}, 64'(err_m));

    // simultaneous push and pop at occupancy 4
    for (int i = 0; i < 4; i++) inject(mk(3'(3 + i), 3'd2, 16'hC000 + 16'(i)), 1'b1);
    grant = 1'b1; inj_valid = 1'b1; inj_msg = mk(3'd7, 3'd2, 16'hC0DE);
    #2;
    chk("inj_ready_pushpop", {63'd0, inj_ready}, 64'd1);
    chk("bus_out_pushpop", {42'd0, bus_out}, {42'd0, exp_q.pop_front()});
    exp_q.push_back(inj_msg);
    tick();
    grant = 1'b0; inj_valid = 1'b0;
    tmp = exp_q[0];
    chk("head_advanced", {61'd0, req_dest}, {61'd0, tmp[MS-1 -: NCD]});
    for (int i = 0; i < 4; i++) grant_pop("drain_pushpop");
    chk("occ_4_kept", {63'd0, fifo_empty}, 64'd1);

    // push on full is rejected even with a simultaneous pop
    for (int i = 0; i < 8; i++) inject(mk(3'(3 + (i % 5)), 3'd1, 16'hD000 + 16'(i)), 1'b1);
    chk("full_inject", {63'd0, fifo_full}, 64'd1);
    rx_en = 1'b1; bus_in = mk(3'd6, 3'd0, 16'hBAD1); grant = 1'b1;
    #2;
    chk("bus_out_full_fwd", {42'd0, bus_out}, {42'd0, exp_q.pop_front()});
    if (drop_m < 3) drop_m++;
    tick();
    rx_en = 1'b0; grant = 1'b0;
    chk("drop_count_2", {62'd0, drop_count}, 64'(drop_m));
    inject(mk(3'd4, 3'd1, 16'hD100), 1'b1);
    inj_valid = 1'b1; inj_msg = mk(3'd5, 3'd1, 16'hD200); grant = 1'b1;
    #2;
    chk("inj_ready_full_pop", {63'd0, inj_ready}, 64'd0);
    chk("bus_out_full_inj", {42'd0, bus_out}, {42'd0, exp_q.pop_front()});
    tick();
    inj_valid = 1'b0; grant = 1'b0;
    for (int i = 0; i < 7; i++) grant_pop("drain_full");
    chk("empty_after_full", {63'd0, fifo_empty}, 64'd1);

    // bypass and grant priority
    bypass = 1'b1; bus_in = mk(3'd6, 3'd5, 16'h7777);
    #2;
    chk("bypass", {42'd0, bus_out}, {42'd0, 3'd6, 3'd5, 16'h7777});
    grant = 1'b1;
    #1;
    chk("bypass_grant_empty", {42'd0, bus_out}, {42'd0, 3'd6, 3'd5, 16'h7777});
    tick();
    grant = 1'b0;
    inject(mk(3'd3, 3'd2, 16'h3333), 1'b1);
    grant_pop("grant_over_bypass");
    bypass = 1'b0; bus_in = '0;

    // reset with three queued entries discards them
    for (int i = 0; i < 3; i++) inject(mk(3'd5, 3'd2, 16'hE000 + 16'(i)), 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_mid_empty", {63'd0, fifo_empty}, 64'd1);
    chk("rst_mid_counts", {60'd0, drop_count, err_count}, 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    grant = 1'b1;
    #2;
    chk("no_output_after_rst", {42'd0, bus_out}, 64'd0);
    tick();
    grant = 1'b0;
    chk("empty_after_rst", {63'd0, fifo_empty}, 64'd1);
    inject(mk(3'd7, 3'd2, 16'hF00D), 1'b1);
    grant_pop("post_rst_order");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
